chimera_addr_map_ctrl: RTL and testbench
========================================

Name: chimera_addr_map_ctrl

Overview:
Runtime-programmable address-map controller replacing the static, compile-time region tables of the SoC configuration. Holds NumRules region entries (start, end, target index, enable) written over APB into a shadow table and atomically committed to an active table. A pipelined lookup port decodes request addresses against the active table. Sits on the external register bus beside the top-level config registers and feeds routing and isolation logic for the cluster domain.

Parameters:
NumRules, 8, number of region entries (1..64)
AddrWidth, 32, lookup address width (1..32)
IdxWidth, 8, target index width (1..31)
DefaultIdx, 0, index returned on a miss

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
paddr_i  in  12  APB byte offset inside the block
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  APB write
pwdata_i  in  32  APB write data
pstrb_i  in  4  APB byte strobes
pready_o  out  1  APB ready
prdata_o  out  32  APB read data
pslverr_o  out  1  APB error
req_valid_i  in  1  lookup request valid
req_ready_o  out  1  lookup request ready
req_addr_i  in  AddrWidth  lookup address
rsp_valid_o  out  1  lookup result valid
rsp_ready_i  in  1  lookup result ready
rsp_hit_o  out  1  an enabled rule matched
rsp_idx_o  out  IdxWidth  matched index, or DefaultIdx on a miss

Behaviour:
- One clock domain: clk_i. Reset rst_i is asynchronous and active-high.
- Reset state: both tables all zero, with every rule disabled. lock=0, pending=0, rsp_valid_o=0, rsp_hit_o=0, rsp_idx_o=DefaultIdx, prdata_o=0, pslverr_o=0. pready_o is combinationally 1.
- Register map (shadow table):
  - Rule i at offset 0x10*i: +0x0 START, +0x4 END (bits above AddrWidth read 0), +0x8 {EN[31], IDX[IdxWidth-1:0]}.
  - 0x800 CTRL: bit0 COMMIT (write-1 pulse, reads 0), bit1 LOCK (write-1 sticky, cleared only by reset).
  - 0x804 STATUS: bit0 PENDING, bits[15:8] NumRules (read-only).
- APB transfers:
  - Zero wait state: the access completes in the cycle with psel_i & penable_i.
  - Writes honour pstrb_i per byte. prdata_o and pslverr_o are valid in the access phase only and are 0 otherwise.
  - pslverr_o=1 on: an unmapped offset (reads return 0), a rule index >= NumRules, a write to a rule or to COMMIT while LOCK=1, or a write to STATUS. Erroring writes have no effect.
  - Writing LOCK=1 while locked is not an error.
- Commit FSM, states IDLE and COPY:
  - IDLE -> COPY on an accepted COMMIT write. PENDING reads 1 from the following cycle.
  - In COPY: the shadow table is copied whole into the active table at the end of the cycle. req_ready_o=0 for this cycle. Next state is IDLE and PENDING returns to 0.
  - A COMMIT write received in COPY is ignored, with no error.
  - Rule writes during COPY go to the shadow table only. Whether they land in this copy: a write in the same cycle as COPY is not included.
- Lookup:
  - req_ready_o = (state==IDLE) & (!rsp_valid_o | rsp_ready_i).
  - On accept, the result is registered with 1-cycle latency and held stable until rsp_ready_i.
  - Match condition for rule i: EN & START <= addr < END, unsigned, with END exclusive. START >= END never matches.
  - Lowest matching index wins. No match gives hit=0 and idx=DefaultIdx.
  - Lookups always use the active table, never the shadow table.
  - When a response is consumed and a new request is accepted in the same cycle, throughput is one lookup per cycle.
- Reset mid-operation: any in-flight response is dropped and any pending commit is lost.

Test Plan:
- Reset, then lookup 0x4000_0000 -> rsp_hit_o=0, rsp_idx_o=0 one cycle after accept. STATUS reads 0x0000_0800.
- Program rule0 {0x4000_0000, 0x4040_0000, EN, IDX 4} with no commit, then lookup 0x4000_0010 -> miss. Write COMMIT -> req_ready_o low for 1 cycle, PENDING=1 for that cycle. Same lookup then -> hit, idx 4.
- Overlapping rules: rule1 [0x4000_0000, 0x4100_0000) idx 2, rule3 [0x4080_0000, 0x40C0_0000) idx 7, committed. Lookup 0x4080_0000 -> idx 2. Lookup 0x40FF_FFFF -> idx 2. Lookup 0x4100_0000 -> miss (END exclusive).
- Back-pressure: hold rsp_ready_i=0 for 5 cycles with req_valid_i=1 -> req_ready_o=0 and rsp_* stable throughout. Release -> back-to-back results at 1 per cycle.
- Set LOCK, then write rule0 START and COMMIT -> pslverr_o=1 and the active table is unchanged. Read offset 0x900 -> pslverr_o=1, prdata_o=0.
- Assert rst_i asynchronously during COPY with rsp_valid_o=1 -> rsp_valid_o=0 immediately. After reset, LOCK=0 and all lookups miss.

Source files
------------

// File: rtl/chimera_addr_map_ctrl.sv
// Runtime-programmable address map: APB-written shadow rule table, atomic commit into
// an active table, and a registered lookup port that decodes against the active table.
module chimera_addr_map_ctrl #(
    parameter int unsigned NumRules   = 8,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned IdxWidth   = 8,
    parameter int unsigned DefaultIdx = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [11:0]          paddr_i,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [31:0]          pwdata_i,
    input  logic [3:0]           pstrb_i,
    output logic                 pready_o,
    output logic [31:0]          prdata_o,
    output logic                 pslverr_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_hit_o,
    output logic [IdxWidth-1:0]  rsp_idx_o
);

    localparam logic [6:0]          NUM_RULES_7 = 7'(NumRules);
    localparam logic [7:0]          NUM_RULES_8 = 8'(NumRules);
    localparam logic [IdxWidth-1:0] DEF_IDX     = IdxWidth'(DefaultIdx);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_COPY = 1'b1} state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  w_copy;
    logic                  r_lock;
    logic [AddrWidth-1:0]  r_sh_start [NumRules];
    logic [AddrWidth-1:0]  r_sh_end   [NumRules];
    logic [IdxWidth-1:0]   r_sh_idx   [NumRules];
    logic                  r_sh_en    [NumRules];
    logic [AddrWidth-1:0]  r_ac_start [NumRules];
    logic [AddrWidth-1:0]  r_ac_end   [NumRules];
    logic [IdxWidth-1:0]   r_ac_idx   [NumRules];
    logic                  r_ac_en    [NumRules];
    logic                  r_rsp_valid;
    logic                  r_rsp_hit;
    logic [IdxWidth-1:0]   r_rsp_idx;

    logic                  w_access, w_is_rule, w_is_ctrl, w_is_stat;
    logic                  w_unmapped, w_lock_err, w_err, w_wr, w_wr_rule;
    logic                  w_commit_bit, w_lock_bit, w_commit;
    logic [6:0]            w_rule_sel;
    logic [1:0]            w_field;
    logic [AddrWidth-1:0]  w_sel_start, w_sel_end;
    logic [IdxWidth-1:0]   w_sel_idx;
    logic                  w_sel_en;
    logic [31:0]           w_rd_word;
    logic                  w_lk_hit;
    logic [IdxWidth-1:0]   w_lk_idx;
    logic                  w_req_ready;

    assign w_access     = psel_i & penable_i;
    assign w_is_rule    = ~paddr_i[11];
    assign w_rule_sel   = paddr_i[10:4];
    assign w_field      = paddr_i[3:2];
    assign w_is_ctrl    = (paddr_i[11:2] == 10'h200);
    assign w_is_stat    = (paddr_i[11:2] == 10'h201);
    assign w_commit_bit = pstrb_i[0] & pwdata_i[0];
    assign w_lock_bit   = pstrb_i[0] & pwdata_i[1];
    // Unaligned byte offsets are treated as unmapped; field +0xC of a rule is unmapped too.
    assign w_unmapped   = (|paddr_i[1:0]) |
                          (w_is_rule ? ((w_rule_sel >= NUM_RULES_7) | (w_field == 2'd3))
                                     : ~(w_is_ctrl | w_is_stat));
    assign w_lock_err   = pwrite_i & r_lock & (w_is_rule | (w_is_ctrl & w_commit_bit));
    assign w_err        = w_access & (w_unmapped | w_lock_err | (pwrite_i & w_is_stat));
    assign w_wr         = w_access & pwrite_i & ~w_err;
    assign w_wr_rule    = w_wr & w_is_rule;
    assign w_commit     = w_wr & w_is_ctrl & w_commit_bit;

    assign pready_o     = 1'b1;
    assign pslverr_o    = w_err;
    assign prdata_o     = (w_access & ~pwrite_i & ~w_err) ? w_rd_word : 32'd0;

    // Shadow-table read mux for the addressed rule / control / status word.
    always_comb begin
        w_sel_start = {AddrWidth{1'b0}};
        w_sel_end   = {AddrWidth{1'b0}};
        w_sel_idx   = {IdxWidth{1'b0}};
        w_sel_en    = 1'b0;
        for (int i = 0; i < NumRules; i++) begin
            if (w_rule_sel == 7'(i)) begin
                w_sel_start = r_sh_start[i];
                w_sel_end   = r_sh_end[i];
                w_sel_idx   = r_sh_idx[i];
                w_sel_en    = r_sh_en[i];
            end else begin
                w_sel_start = w_sel_start;
                w_sel_end   = w_sel_end;
                w_sel_idx   = w_sel_idx;
                w_sel_en    = w_sel_en;
            end
        end
        w_rd_word = 32'd0;
        if (w_is_rule) begin
            case (w_field)
                2'd0:    w_rd_word = 32'(w_sel_start);
                2'd1:    w_rd_word = 32'(w_sel_end);
                2'd2:    w_rd_word = 32'(w_sel_idx) | {w_sel_en, 31'd0};
                default: w_rd_word = 32'd0;
            endcase
        end else if (w_is_ctrl) begin
            w_rd_word = {30'd0, r_lock, 1'b0};
        end else if (w_is_stat) begin
            w_rd_word = {16'd0, NUM_RULES_8, 7'd0, (r_state == ST_COPY)};
        end else begin
            w_rd_word = 32'd0;
        end
    end

    // Commit FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Commit FSM next state; a COMMIT seen during COPY is silently dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_copy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_commit) begin
                    w_state_nxt = ST_COPY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COPY: begin
                w_copy      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sticky lock bit, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock <= 1'b0;
        end else if (w_wr & w_is_ctrl & w_lock_bit) begin
            r_lock <= 1'b1;
        end
    end

    // Shadow table: byte-strobed APB writes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRules; i++) begin
                r_sh_start[i] <= {AddrWidth{1'b0}};
                r_sh_end[i]   <= {AddrWidth{1'b0}};
                r_sh_idx[i]   <= {IdxWidth{1'b0}};
                r_sh_en[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NumRules; i++) begin
                if (w_wr_rule && (w_rule_sel == 7'(i))) begin
                    case (w_field)
                        2'd0: r_sh_start[i] <= AddrWidth'(merge_bytes(32'(r_sh_start[i]), pwdata_i, pstrb_i));
                        2'd1: r_sh_end[i]   <= AddrWidth'(merge_bytes(32'(r_sh_end[i]), pwdata_i, pstrb_i));
                        2'd2: begin
                            r_sh_idx[i] <= IdxWidth'(merge_bytes(32'(r_sh_idx[i]), pwdata_i, pstrb_i));
                            r_sh_en[i]  <= pstrb_i[3] ? pwdata_i[31] : r_sh_en[i];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Active table: whole-table snapshot of the shadow during COPY.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRules; i++) begin
                r_ac_start[i] <= {AddrWidth{1'b0}};
                r_ac_end[i]   <= {AddrWidth{1'b0}};
                r_ac_idx[i]   <= {IdxWidth{1'b0}};
                r_ac_en[i]    <= 1'b0;
            end
        end else if (w_copy) begin
            for (int i = 0; i < NumRules; i++) begin
                r_ac_start[i] <= r_sh_start[i];
                r_ac_end[i]   <= r_sh_end[i];
                r_ac_idx[i]   <= r_sh_idx[i];
                r_ac_en[i]    <= r_sh_en[i];
            end
        end
    end

    // Priority decode: scanning downwards leaves the lowest matching rule in place.
    always_comb begin
        w_lk_hit = 1'b0;
        w_lk_idx = DEF_IDX;
        for (int i = NumRules - 1; i >= 0; i--) begin
            if (r_ac_en[i] && (req_addr_i >= r_ac_start[i]) && (req_addr_i < r_ac_end[i])) begin
                w_lk_hit = 1'b1;
                w_lk_idx = r_ac_idx[i];
            end else begin
                w_lk_hit = w_lk_hit;
                w_lk_idx = w_lk_idx;
            end
        end
    end

    assign w_req_ready = (r_state == ST_IDLE) & (~r_rsp_valid | rsp_ready_i);
    assign req_ready_o = w_req_ready;

    // Response register, held until the consumer takes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_idx   <= DEF_IDX;
        end else if (w_req_ready && req_valid_i) begin
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= w_lk_hit;
            r_rsp_idx   <= w_lk_idx;
        end else if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_hit_o   = r_rsp_hit;
    assign rsp_idx_o   = r_rsp_idx;

endmodule

// File: tb/tb_chimera_addr_map_ctrl.sv
// Bench for chimera_addr_map_ctrl: rule-table model checked every cycle plus
// directed APB/lookup vectors with hand-computed expectations.
module tb_chimera_addr_map_ctrl;

    localparam int NR = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] paddr = 12'd0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = 32'd0;
    logic [3:0]  pstrb = 4'd0;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_hit;
    logic [7:0]  rsp_idx;
    logic        cur_err = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    chimera_addr_map_ctrl #(.NumRules(NR), .AddrWidth(32), .IdxWidth(8), .DefaultIdx(0)) dut (
        .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready),
        .prdata_o(prdata), .pslverr_o(pslverr), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_hit_o(rsp_hit), .rsp_idx_o(rsp_idx)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: shadow/active tables as plain words; idx word keeps EN in bit 31.
    logic [31:0] m_sh_start [NR], m_sh_end [NR], m_sh_idx [NR];
    logic [31:0] m_ac_start [NR], m_ac_end [NR], m_ac_idx [NR];
    logic        m_copy = 1'b0, m_valid = 1'b0, m_hit = 1'b0;
    logic [7:0]  m_idx = 8'd0;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Returns {hit, idx}: first enabled rule in index order whose [start, end) holds the address.
    function automatic logic [8:0] mlook(input logic [31:0] a);
        for (int i = 0; i < NR; i++)
            if (m_ac_idx[i][31] && a >= m_ac_start[i] && a < m_ac_end[i])
                return {1'b1, m_ac_idx[i][7:0]};
        return 9'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_sh_start[i] <= 32'd0; m_sh_end[i] <= 32'd0; m_sh_idx[i] <= 32'd0;
                m_ac_start[i] <= 32'd0; m_ac_end[i] <= 32'd0; m_ac_idx[i] <= 32'd0;
            end
            m_copy <= 1'b0; m_valid <= 1'b0; m_hit <= 1'b0; m_idx <= 8'd0;
        end else begin
            if (m_copy) begin
                m_ac_start <= m_sh_start; m_ac_end <= m_sh_end; m_ac_idx <= m_sh_idx;
            end
            m_copy <= 1'b0;
            if (psel && penable && pwrite && !cur_err) begin
                if (paddr < 12'h800) begin
                    case (paddr[3:2])
                        2'd0: m_sh_start[paddr[6:4]] <= bmerge(m_sh_start[paddr[6:4]], pwdata, pstrb);
                        2'd1: m_sh_end[paddr[6:4]]   <= bmerge(m_sh_end[paddr[6:4]], pwdata, pstrb);
                        2'd2: m_sh_idx[paddr[6:4]]   <= bmerge(m_sh_idx[paddr[6:4]], pwdata, pstrb) & 32'h8000_00FF;
                        default: ;
                    endcase
                end else if (paddr == 12'h800 && pstrb[0] && pwdata[0] && !m_copy) begin
                    m_copy <= 1'b1;
                end
            end
            if (req_valid && !m_copy && (!m_valid || rsp_ready)) begin
                m_valid <= 1'b1;
                {m_hit, m_idx} <= mlook(req_addr);
            end else if (rsp_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("req_ready", {31'd0, req_ready}, {31'd0, !m_copy && (!m_valid || rsp_ready)});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("rsp_hit", {31'd0, rsp_hit}, {31'd0, m_hit});
            chk("rsp_idx", {24'd0, rsp_idx}, {24'd0, m_idx});
        end
    end

    task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic ee, input logic [31:0] er, input string nm);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; cur_err = ee;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk({nm, "_pslverr"}, {31'd0, pslverr}, {31'd0, ee});
        chk({nm, "_prdata"}, prdata, wr ? 32'd0 : er);
        chk({nm, "_pready"}, {31'd0, pready}, 32'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; cur_err = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] a, input logic eh, input logic [7:0] ei, input string nm);
        bit ok;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({nm, "_hit"}, {31'd0, rsp_hit}, {31'd0, eh});
        chk({nm, "_idx"}, {24'd0, rsp_idx}, {24'd0, ei});
    endtask

    task automatic prog_rule0();
        apb(1'b1, 12'h000, 32'h4000_0000, 4'hF, 1'b0, 32'd0, "r0_start");
        apb(1'b1, 12'h004, 32'h4040_0000, 4'hF, 1'b0, 32'd0, "r0_end");
        apb(1'b1, 12'h008, 32'h8000_0004, 4'hF, 1'b0, 32'd0, "r0_ctl");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_hit", {31'd0, rsp_hit}, 32'd0);
        chk("rst_rsp_idx", {24'd0, rsp_idx}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("rst_pready", {31'd0, pready}, 32'd1);
        lookup(32'h4000_0000, 1'b0, 8'd0, "reset_miss");
        apb(1'b0, 12'h804, 32'd0, 4'h0, 1'b0, 32'h0000_0800, "status_reset");

        prog_rule0();
        apb(1'b0, 12'h008, 32'd0, 4'h0, 1'b0, 32'h8000_0004, "r0_ctl_rd");
        lookup(32'h4000_0010, 1'b0, 8'd0, "shadow_only");

        // Commit, then read STATUS in the COPY cycle by holding the access phase.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h800; pwdata = 32'd1; pstrb = 4'hF; cur_err = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk) chk("commit_pslverr", {31'd0, pslverr}, 32'd0);
        @(posedge clk); #1 pwrite = 1'b0; paddr = 12'h804;
        @(negedge clk);
        chk("pending_set", prdata, 32'h0000_0801);
        chk("copy_ready_low", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        apb(1'b0, 12'h804, 32'd0, 4'h0, 1'b0, 32'h0000_0800, "pending_clear");
        lookup(32'h4000_0010, 1'b1, 8'd4, "committed_hit");

        apb(1'b1, 12'h010, 32'h4000_0000, 4'hF, 1'b0, 32'd0, "r1_start");
        apb(1'b1, 12'h014, 32'h4100_0000, 4'hF, 1'b0, 32'd0, "r1_end");
        apb(1'b1, 12'h018, 32'h8000_0002, 4'hF, 1'b0, 32'd0, "r1_ctl");
        apb(1'b1, 12'h030, 32'h4080_0000, 4'hF, 1'b0, 32'd0, "r3_start");
        apb(1'b1, 12'h034, 32'h40C0_0000, 4'hF, 1'b0, 32'd0, "r3_end");
        apb(1'b1, 12'h038, 32'h8000_0007, 4'hF, 1'b0, 32'd0, "r3_ctl");
        apb(1'b1, 12'h024, 32'hFFFF_FFFF, 4'h1, 1'b0, 32'd0, "r2_end_strb");
        apb(1'b0, 12'h024, 32'd0, 4'h0, 1'b0, 32'h0000_00FF, "r2_end_strb_rd");
        apb(1'b1, 12'h020, 32'h6000_0000, 4'hF, 1'b0, 32'd0, "r2_start");
        apb(1'b1, 12'h024, 32'h6000_0000, 4'hF, 1'b0, 32'd0, "r2_end");
        apb(1'b1, 12'h028, 32'h8000_0009, 4'hF, 1'b0, 32'd0, "r2_ctl");
        apb(1'b1, 12'h800, 32'h0000_0001, 4'hF, 1'b0, 32'd0, "commit2");
        lookup(32'h4080_0000, 1'b1, 8'd2, "ovl_lowest");
        lookup(32'h40FF_FFFF, 1'b1, 8'd2, "ovl_top");
        lookup(32'h4100_0000, 1'b0, 8'd0, "end_exclusive");
        lookup(32'h6000_0000, 1'b0, 8'd0, "empty_range");
        lookup(32'h403F_FFFF, 1'b1, 8'd4, "rule0_wins");
        lookup(32'h4040_0000, 1'b1, 8'd2, "rule0_end");

        // Back-pressure: response must hold while rsp_ready is low.
        @(posedge clk); #1 rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4000_0010;
        @(posedge clk); #1 req_addr = 32'h4080_0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_idx", {24'd0, rsp_idx}, 32'd4);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 req_addr = 32'h40FF_FFFF;
        @(negedge clk) chk("b2b0_idx", {24'd0, rsp_idx}, 32'd2);
        @(posedge clk); #1 req_addr = 32'h4100_0000;
        @(negedge clk) chk("b2b1_idx", {24'd0, rsp_idx}, 32'd2);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b2_hit", {31'd0, rsp_hit}, 32'd0);

        apb(1'b1, 12'h800, 32'h0000_0002, 4'hF, 1'b0, 32'd0, "lock_set");
        apb(1'b0, 12'h800, 32'd0, 4'h0, 1'b0, 32'h0000_0002, "lock_rd");
        apb(1'b1, 12'h000, 32'h1000_0000, 4'hF, 1'b1, 32'd0, "lock_rule_wr");
        apb(1'b1, 12'h800, 32'h0000_0001, 4'hF, 1'b1, 32'd0, "lock_commit");
        apb(1'b1, 12'h800, 32'h0000_0002, 4'hF, 1'b0, 32'd0, "lock_again");
        apb(1'b0, 12'h900, 32'd0, 4'h0, 1'b1, 32'd0, "unmapped_rd");
        apb(1'b1, 12'h080, 32'h1234_5678, 4'hF, 1'b1, 32'd0, "rule_oor_wr");
        apb(1'b1, 12'h804, 32'h0000_0001, 4'hF, 1'b1, 32'd0, "status_wr");
        apb(1'b0, 12'h000, 32'd0, 4'h0, 1'b0, 32'h4000_0000, "start_unchanged");
        lookup(32'h4000_0010, 1'b1, 8'd4, "active_unchanged");

        // Reset during COPY with a response held.
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        prog_rule0();
        @(posedge clk); #1 rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4000_0010;
        @(posedge clk); #1 req_valid = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h800; pwdata = 32'd1; pstrb = 4'hF; cur_err = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        chk("pre_rst_copy", {31'd0, req_ready}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_drop_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_drop_idx", {24'd0, rsp_idx}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; rsp_ready = 1'b1;
        apb(1'b0, 12'h800, 32'd0, 4'h0, 1'b0, 32'd0, "lock_cleared");
        apb(1'b0, 12'h804, 32'd0, 4'h0, 1'b0, 32'h0000_0800, "pending_lost");
        lookup(32'h4000_0010, 1'b0, 8'd0, "post_rst_miss");
        apb(1'b0, 12'h000, 32'd0, 4'h0, 1'b0, 32'd0, "shadow_cleared");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
